ring_phase_monitor: RTL
=======================

Name: ring_phase_monitor

Overview:
- Sits directly downstream of the 4-bit one-hot ring counter and consumes its rotating output every clock.
- Validates that the ring stays one-hot and steps in the right-rotate direction: 1000 -> 0100 -> 0010 -> 0001 -> 1000.
- Encodes the active bit to a binary phase index and counts full revolutions.
- Flags a sticky fault when the ring corrupts after lock.

Parameters:
- W, 4, ring width in bits (>= 2).
- LOCK_CNT, 4, consecutive good advancing steps required to declare lock (>= 1).
- CNT_W, 16, revolution counter width.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- ring  input  W  one-hot ring counter output.
- ring_adv  input  1  1 = ring is expected to step this cycle; 0 = ring is expected to hold.
- clr_err  input  1  single-cycle pulse; clears FAULT.
- phase_idx  output  $clog2(W)  binary index of the set bit in ring.
- locked  output  1  high while state is LOCKED.
- fault  output  1  high while state is FAULT.
- rev_tick  output  1  one-cycle pulse per completed revolution.
- rev_cnt  output  CNT_W  revolution count.

Behaviour:
- Reset is synchronous, active-high, clock clk. On rst = 1 at an edge:
  - state = SEARCH, prev_valid = 0, good_cnt = 0;
  - phase_idx = 0, locked = 0, fault = 0, rev_tick = 0, rev_cnt = 0.
  - rst mid-operation behaves identically.
- Each edge samples ring into prev_ring. All outputs are registered, so each output reflects the ring value present before that edge. Latency is 1 cycle.
- Definitions:
  - onehot = exactly one bit of ring set.
  - expected = {prev_ring[0], prev_ring[W-1:1]} when ring_adv = 1; prev_ring when ring_adv = 0.
  - good = onehot && (!prev_valid || ring == expected).
- phase_idx: loads the index of the set bit whenever onehot; holds its previous value otherwise.
- SEARCH:
  - onehot -> SYNC, prev_valid = 1, good_cnt = 0.
  - Otherwise stay.
- SYNC:
  - good with ring_adv = 1 -> good_cnt + 1. When the count reaches LOCK_CNT -> LOCKED.
  - good with ring_adv = 0 -> stay, count unchanged.
  - !good -> SEARCH, good_cnt = 0, prev_valid = 0. No fault is raised.
- LOCKED:
  - good -> stay.
  - !good -> FAULT.
  - A wrap step (prev_ring[0] = 1 and ring[W-1] = 1 with ring_adv = 1) sets rev_tick = 1 for one cycle and increments rev_cnt modulo 2^CNT_W.
- FAULT:
  - Ring is ignored; phase_idx still tracks one-hot samples.
  - rev_cnt is frozen; rev_tick = 0.
  - clr_err = 1 -> SEARCH with prev_valid = 0.
- clr_err is ignored outside FAULT. In LOCKED, a bad sample together with clr_err still enters FAULT.
- locked and fault are registered decodes of the next state; both are never high together.
- rev_cnt is not cleared by fault or clr_err; only rst clears it.

Optional Feature:
- Macro: RING_MON_ERR_CNT_EN.
- When defined:
  - Adds output err_cnt (8 bits).
  - Counts !good samples occurring in SYNC or LOCKED state.
  - Saturates at 255.
  - Cleared only by rst; reset value 0.
- When undefined: port and logic are absent, and all other behaviour is identical.

Test Plan:
- W = 4, LOCK_CNT = 4; reset, then ring 1000, 0100, 0010, 0001, 1000 with ring_adv = 1 -> phase_idx 3, 2, 1, 0, 3; locked rises after the edge sampling the second 1000; fault = 0.
- Locked, continue 0100 ... 0001 -> 1000 -> rev_tick high exactly one cycle; rev_cnt 0 -> 1. Two more revolutions -> rev_cnt = 3.
- Locked, drive 1100 -> locked = 0, fault = 1. Fault holds across valid ring values. clr_err pulse -> fault = 0, state SEARCH; re-lock requires 4 fresh good steps. With the macro defined, err_cnt = 1.
- Locked, ring_adv = 0 and ring held at 0010 for 3 cycles -> locked stays 1. Next cycle ring_adv = 0 while ring changes to 0001 -> fault = 1.
- In SYNC after 2 good steps, jump 0100 -> 0001 -> back to SEARCH, fault = 0, locked = 0; lock is achieved only after 4 further consecutive good steps.
- Locked with rev_cnt = 5; assert rst for one edge -> phase_idx = 0, locked = 0, fault = 0, rev_tick = 0, rev_cnt = 0.

Source files
------------

// File: rtl/ring_phase_monitor.sv
// rtl/ring_phase_monitor.sv - one-hot ring counter lock/phase/revolution monitor
// Optional err_cnt output enabled by defining RING_MON_ERR_CNT_EN.
module ring_phase_monitor #(
    parameter int W        = 4,
    parameter int LOCK_CNT = 4,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [W-1:0]         ring,
    input  logic                 ring_adv,
    input  logic                 clr_err,
    output logic [$clog2(W)-1:0] phase_idx,
    output logic                 locked,
    output logic                 fault,
    output logic                 rev_tick,
`ifdef RING_MON_ERR_CNT_EN
    output logic [7:0]           err_cnt,
`endif
    output logic [CNT_W-1:0]     rev_cnt
);

    localparam int IW = $clog2(W);
    localparam int GW = $clog2(LOCK_CNT + 1);

    localparam logic [1:0] S_SEARCH = 2'd0;
    localparam logic [1:0] S_SYNC   = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;
    localparam logic [1:0] S_FAULT  = 2'd3;

    logic [1:0]       r_state;
    logic [W-1:0]     r_prev_ring;
    logic             r_prev_valid;
    logic [GW-1:0]    r_good_cnt;
    logic [IW-1:0]    r_phase_idx;
    logic             r_rev_tick;
    logic [CNT_W-1:0] r_rev_cnt;

    logic             w_onehot;
    logic [W-1:0]     w_expected;
    logic             w_good;
    logic             w_wrap;
    logic [IW-1:0]    w_idx;

    always_comb begin
        w_onehot   = (ring != '0) && ((ring & (ring - 1'b1)) == '0);
        w_expected = ring_adv ? {r_prev_ring[0], r_prev_ring[W-1:1]} : r_prev_ring;
        w_good     = w_onehot && (!r_prev_valid || (ring == w_expected));
        w_wrap     = ring_adv && r_prev_ring[0] && ring[W-1];
        w_idx      = '0;
        for (int i = 0; i < W; i++) begin
            if (ring[i]) begin
                w_idx = IW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_SEARCH;
            r_prev_ring  <= '0;
            r_prev_valid <= 1'b0;
            r_good_cnt   <= '0;
            r_phase_idx  <= '0;
            r_rev_tick   <= 1'b0;
            r_rev_cnt    <= '0;
        end else begin
            r_prev_ring <= ring;
            r_rev_tick  <= 1'b0;
            if (w_onehot) begin
                r_phase_idx <= w_idx;
            end
            case (r_state)
                S_SEARCH: begin
                    if (w_onehot) begin
                        r_state      <= S_SYNC;
                        r_prev_valid <= 1'b1;
                        r_good_cnt   <= '0;
                    end
                end
                S_SYNC: begin
                    if (!w_good) begin
                        r_state      <= S_SEARCH;
                        r_prev_valid <= 1'b0;
                        r_good_cnt   <= '0;
                    end else if (ring_adv) begin
                        r_good_cnt <= r_good_cnt + 1'b1;
                        if (r_good_cnt == GW'(LOCK_CNT - 1)) begin
                            r_state <= S_LOCKED;
                        end
                    end
                end
                S_LOCKED: begin
                    // clr_err has no effect here, so a bad sample always faults
                    if (!w_good) begin
                        r_state <= S_FAULT;
                    end else if (w_wrap) begin
                        r_rev_tick <= 1'b1;
                        r_rev_cnt  <= r_rev_cnt + 1'b1;
                    end
                end
                default: begin
                    if (clr_err) begin
                        r_state      <= S_SEARCH;
                        r_prev_valid <= 1'b0;
                        r_good_cnt   <= '0;
                    end
                end
            endcase
        end
    end

`ifdef RING_MON_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if ((r_state == S_SYNC || r_state == S_LOCKED) && !w_good
                     && r_err_cnt != 8'hFF) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

    assign phase_idx = r_phase_idx;
    assign locked    = (r_state == S_LOCKED);
    assign fault     = (r_state == S_FAULT);
    assign rev_tick  = r_rev_tick;
    assign rev_cnt   = r_rev_cnt;

endmodule
